relay_encode_param: RTL

Parametrised successor relay encoder for the relay FPGA path. It oversamples a demodulated bitstream, frames it into fixed sample windows, and detects frame start, symbol and end patterns. Each recognised half-symbol pattern is re-emitted as a timed output pulse for the relay link. Compared with the fixed 8-sample/16-clock encoder, it adds:
- configurable prescaler, window and pulse widths;
- a uniform polarity-selectable mode;
- invalid-symbol abort;
- frame status outputs.

---
 rtl/relay_encode_param_if.sv | 21 ++
 rtl/relay_encode_param.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/relay_encode_param_if.sv
// Relay encoder link bundle: demodulated input and mode towards the encoder, pulse and frame status back.
// master drives the bitstream side, slave is the encoder itself.
interface relay_encode_param_if;
  logic       mode;
  logic       data_in;
  logic       data_out;
  logic       comm_active;
  logic       frame_done;
  logic       frame_err;
  logic [7:0] sym_count;

  modport master (
    output mode, data_in,
    input  data_out, comm_active, frame_done, frame_err, sym_count
  );

  modport slave (
    input  mode, data_in,
    output data_out, comm_active, frame_done, frame_err, sym_count
  );
endinterface

// File: rtl/relay_encode_param.sv
// Oversampling relay encoder: frames samples into windows and re-emits A/B half-symbols as timed pulses.
// Latency 1 clk from strobe to symbol-A pulse; no backpressure. RELAY_ENCODE_MAJORITY_EN enables a 3-tap glitch filter.
module relay_encode_param #(
  parameter int DIV_LOG2   = 4,
  parameter int WIN        = 8,
  parameter int HALF_PULSE = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  relay_encode_param_if.slave  bus
);
  localparam int H  = WIN / 2;
  localparam int PW = $clog2(WIN);
  localparam int CW = $clog2(2 * HALF_PULSE + 1);

  localparam logic [DIV_LOG2-1:0] PRE_ONE = 1;
  localparam logic [PW-1:0]       PH_ONE  = 1;
  localparam logic [PW-1:0]       PH_LAST = PW'(WIN - 1);
  localparam logic [CW-1:0]       C_ONE   = 1;
  localparam logic [CW-1:0]       HP      = CW'(HALF_PULSE);
  localparam logic [CW-1:0]       HP_M1   = CW'(HALF_PULSE - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [DIV_LOG2-1:0] presc;
  logic [WIN-1:0]      win, w;
  logic [PW-1:0]       phase, phase_nxt;
  logic                marker, marker_nxt, mk_base;
  logic [7:0]          sym_count, sym_nxt, sym_base;
  logic [CW-1:0]       hi_cnt, hi_nxt, dly_cnt, dly_nxt;
  logic                dout, dout_nxt;
  logic                done_q, done_nxt, err_q, err_nxt;
  logic                strobe, s, start, eval;
  logic                ev_end, ev_mark, ev_a, ev_b, ev_err;

  assign strobe = &presc;

`ifdef RELAY_ENCODE_MAJORITY_EN
  // Two history taps plus the live input form the three-sample vote.
  logic [1:0] hist;
  always_ff @(posedge clk) begin
    if (reset) hist <= '0;
    else       hist <= {hist[0], bus.data_in};
  end
  assign s = ((bus.data_in & hist[0]) | (bus.data_in & hist[1]) | (hist[0] & hist[1])) ^ bus.mode;
`else
  assign s = bus.data_in ^ bus.mode;
`endif

  assign w         = {win[WIN-2:0], s};
  assign phase_nxt = (phase == PH_LAST) ? '0 : phase + PH_ONE;
  assign mk_base   = start ? 1'b0 : marker;
  assign sym_base  = start ? 8'd0 : sym_count;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    start     = 1'b0;
    eval      = 1'b0;
    ev_end    = 1'b0;
    ev_mark   = 1'b0;
    ev_a      = 1'b0;
    ev_b      = 1'b0;
    ev_err    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE:   if (strobe && (w[WIN-1:WIN-2] == 2'b00) && (&w[H-1:0])) begin
                start = 1'b1;
                eval  = 1'b1;
              end
      ACTIVE: eval = strobe && (phase_nxt == '0);
      default: ;
    endcase
    if (eval) begin
      if (&w) begin
        if (mk_base) ev_end  = 1'b1;
        else         ev_mark = 1'b1;
      end
      else if (&w[H-1:0])   ev_a   = 1'b1;
      else if (&w[WIN-1:H]) ev_b   = 1'b1;
      else                  ev_err = 1'b1;
    end
    if (start)           state_nxt = ACTIVE;
    if (ev_end || ev_err) state_nxt = IDLE;
  end

  always_comb begin
    marker_nxt = mk_base;
    if (ev_mark || ev_a) marker_nxt = 1'b1;
    if (ev_b)            marker_nxt = 1'b0;
    sym_nxt = sym_base;
    if ((ev_a || ev_b) && (sym_base != 8'hFF)) sym_nxt = sym_base + 8'd1;
    done_nxt = ev_end;
    err_nxt  = ev_err;
    hi_nxt   = hi_cnt;
    dly_nxt  = dly_cnt;
    dout_nxt = 1'b0;
    // A new symbol or an abort overrides whatever pulse is running; a frame end does not.
    if (ev_a) begin
      dout_nxt = 1'b1;
      hi_nxt   = HP_M1;
      dly_nxt  = '0;
    end
    else if (ev_b) begin
      hi_nxt  = '0;
      dly_nxt = HP;
    end
    else if (ev_err) begin
      hi_nxt  = '0;
      dly_nxt = '0;
    end
    else if (dly_cnt != '0) begin
      dly_nxt = dly_cnt - C_ONE;
      if (dly_cnt == C_ONE) begin
        dout_nxt = 1'b1;
        hi_nxt   = HP_M1;
      end
    end
    else if (hi_cnt != '0) begin
      hi_nxt   = hi_cnt - C_ONE;
      dout_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      win       <= '0;
      phase     <= '0;
      marker    <= 1'b0;
      sym_count <= 8'd0;
      hi_cnt    <= '0;
      dly_cnt   <= '0;
      dout      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end
    else begin
      presc <= presc + PRE_ONE;
      if (strobe) begin
        win   <= w;
        phase <= start ? '0 : phase_nxt;
      end
      marker    <= marker_nxt;
      sym_count <= sym_nxt;
      hi_cnt    <= hi_nxt;
      dly_cnt   <= dly_nxt;
      dout      <= dout_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
    end
  end

  assign bus.data_out    = dout;
  assign bus.comm_active = (state == ACTIVE);
  assign bus.frame_done  = done_q;
  assign bus.frame_err   = err_q;
  assign bus.sym_count   = sym_count;
endmodule
